// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field layout, opcodes and fetch FSM encoding.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int IMM_W   = 12;

  localparam int OPC_HI = 31;
  localparam int OPC_LO = 27;
  localparam int IMM_HI = 11;
  localparam int IMM_LO = 0;

  localparam logic [4:0] ADD  = 5'b00000;
  localparam logic [4:0] JUMP = 5'b10010;
  localparam logic [4:0] BLE  = 5'b11000;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read bus: req/addr from the fetch unit, rdata/valid from memory.
interface instr_fetch_unit_if #(
  parameter int PC_W = 12
);
  import cpu_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_valid;

  modport master (output imem_req, output imem_addr, input imem_rdata, input imem_valid);
  modport slave  (input imem_req, input imem_addr, output imem_rdata, output imem_valid);
endinterface

// File: rtl/instr_fetch_unit_pc_next_calc.sv
// Combinational next-PC selection: sequential, relative branch, or absolute jump.
module pc_next_calc
  import cpu_pkg::*;
#(
  parameter int PC_W = 12
) (
  input  logic [PC_W-1:0]  pc,
  input  logic [IMM_W-1:0] imm,
  input  logic             branch,
  input  logic             branch_taken,
  input  logic             jump,
  output logic [PC_W-1:0]  next_pc
);

  logic [PC_W-1:0] pc_seq;

  assign pc_seq = pc + PC_W'(1);

  // Jump beats a taken branch; all sums wrap modulo 2^PC_W.
  always_comb begin
    next_pc = pc_seq;
    if (jump)
      next_pc = PC_W'(imm);
    else if (branch && branch_taken)
      next_pc = pc_seq + PC_W'($signed(imm));
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Program counter and instruction register; fetches one word per request over the imem bus.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter int               PC_W     = 12,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter int               TIMEOUT  = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                fetch_start,
  input  logic                pc_update,
  input  logic                Branch,
  input  logic                branch_taken,
  input  logic                Jump,
  instr_fetch_unit_if.master  imem,
  output logic [INSTR_W-1:0]  instruction,
  output logic                fetch_done,
  output logic [PC_W-1:0]     pc,
  output logic                fetch_err
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  fetch_state_t    state;
  logic            pending;
  logic [7:0]      timer;
  logic [PC_W-1:0] next_pc;

  pc_next_calc #(.PC_W(PC_W)) u_pc_next_calc (
    .pc           (pc),
    .imm          (instruction[IMM_HI:IMM_LO]),
    .branch       (Branch),
    .branch_taken (branch_taken),
    .jump         (Jump),
    .next_pc      (next_pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= ST_IDLE;
      pc             <= RESET_PC;
      instruction    <= '0;
      imem.imem_req  <= 1'b0;
      imem.imem_addr <= '0;
      fetch_done     <= 1'b0;
      fetch_err      <= 1'b0;
      pending        <= 1'b0;
      timer          <= '0;
    end else begin
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A commit colliding with a fetch request defers the fetch so it uses the new PC.
          if (pc_update) begin
            pc <= next_pc;
            if (fetch_start)
              pending <= 1'b1;
          end else if (fetch_start || pending) begin
            imem.imem_req  <= 1'b1;
            imem.imem_addr <= pc;
            timer          <= '0;
            pending        <= 1'b0;
            state          <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (pc_update)
            fetch_err <= 1'b1;
          if (imem.imem_valid) begin
            instruction   <= imem.imem_rdata;
            imem.imem_req <= 1'b0;
            fetch_done    <= 1'b1;
            state         <= ST_IDLE;
          end else if (timer == TIMER_LAST) begin
            imem.imem_req <= 1'b0;
            fetch_err     <= 1'b1;
            state         <= ST_IDLE;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of Control_Unit in the multi-cycle CPU.
- Owns the program counter (PC) and the instruction register (IR).
- During the FETCH state it fetches one word from instruction memory over a req/valid handshake and presents it to Control_Unit as `instruction`.
- At instruction commit it updates the PC from the Branch/branch_taken/Jump outputs of Control_Unit.

Parameters:
- PC_W, 12, PC width in words (word-addressed; matches the 12-bit immediate).
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT, 15, max cycles in WAIT before the fetch is aborted (range 1..255).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- fetch_start  in  1  request one fetch (asserted by Control_Unit in FETCH)
- pc_update  in  1  one-cycle commit strobe; PC advances
- Branch  in  1  from Control_Unit
- branch_taken  in  1  from Control_Unit
- Jump  in  1  from Control_Unit
- imem_req  out  1  memory read request
- imem_addr  out  PC_W  read address
- imem_rdata  in  32  read data
- imem_valid  in  1  read data valid
- instruction  out  32  IR contents, to Control_Unit
- fetch_done  out  1  one-cycle pulse: IR just loaded
- pc  out  PC_W  current PC
- fetch_err  out  1  one-cycle pulse on timeout or protocol violation

Behaviour:
- Reset (reset=0, async) sets: pc=RESET_PC, instruction=32'h0, imem_req=0, imem_addr=0, fetch_done=0, fetch_err=0, state=IDLE, pending=0, timer=0.
- Field layout:
  - opcode [31:27], rs [26:22], rt [21:17], rd [16:12], imm [11:0].
- Next-PC (combinational):
  - seq = pc+1.
  - Branch&branch_taken: pc+1+sext(imm), where imm is from the current IR.
  - Jump: zero-extended imm.
  - Jump has priority over Branch.
  - All arithmetic is modulo 2^PC_W; wrap 0xFFF+1 -> 0x000 is legal.
- FSM states IDLE, WAIT.
  - IDLE:
    - pc_update=1: pc<=next-PC.
    - fetch_start=1 (or pending=1) with pc_update=0: imem_req<=1, imem_addr<=pc, timer<=0, pending<=0, go WAIT. Request is visible the cycle after acceptance.
    - fetch_start and pc_update in the same cycle: PC update wins, pending<=1, fetch issues next cycle using the new PC.
  - WAIT:
    - imem_req held 1 and imem_addr held stable until imem_valid.
    - imem_valid=1: instruction<=imem_rdata, imem_req<=0, fetch_done<=1 for exactly one cycle, go IDLE.
    - timer==TIMEOUT-1 without imem_valid: imem_req<=0, fetch_err pulse, IR unchanged, no fetch_done, go IDLE.
    - pc_update in WAIT: ignored (pc unchanged) and fetch_err pulse.
    - fetch_start in WAIT: ignored, no queueing.
- Latency: fetch_start accepted at edge N gives imem_req high after N. With a zero-wait memory (imem_valid combinationally following imem_req), fetch_done is high after edge N+1.
- imem_valid while in IDLE is ignored.
- pc and instruction change only as listed above.
- Reset mid-WAIT aborts immediately: imem_req drops asynchronously and no fetch_done is issued.

Decomposition:
- Package cpu_pkg holds:
  - opcode localparams (ADD=5'b00000 … BLE=5'b11000, JUMP=5'b10010);
  - field bit positions: OPC_HI=31, OPC_LO=27, IMM_HI=11, IMM_LO=0;
  - instruction width 32;
  - fetch state encoding.
- One sub-module: pc_next_calc (combinational next-PC mux and adder, PC_W-parameterised), shared later with a pipelined variant.

Test Plan:
- Sequential: reset, then three fetch_start/pc_update pairs with a zero-wait memory returning mem[a]=32'hA000_0000+a -> IR = A0000000, A0000001, A0000002; pc ends at 3; each fetch_done is exactly 1 cycle wide.
- Branch taken: IR imm=12'hFFE at pc=5, Branch=1, branch_taken=1, pc_update -> pc=4. Same with branch_taken=0 -> pc=6.
- Jump and wrap: IR imm=12'h003, Jump=1, Branch=1 -> pc=3. Separately, pc=0xFFF with sequential update -> pc=0x000.
- Timeout and violation: memory never valid -> fetch_err pulses exactly TIMEOUT=15 cycles after imem_req rises, imem_req drops, IR unchanged. pc_update during WAIT -> fetch_err pulse, pc unchanged.
- Collision and reset: fetch_start and pc_update in the same cycle at pc=7 -> imem_addr=8 one cycle later. reset=0 asserted mid-WAIT -> imem_req=0 and pc=RESET_PC immediately, with no fetch_done.
